// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional blinking is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 4,
  parameter int BLINK_DIV   = 250
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
  output logic                      load_ack,
  output logic [3:0]                digit_out,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int DW   = $clog2(REFRESH_DIV);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]              r_state;
  logic [DW-1:0]           r_div;
  logic [IDXW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_staging;
  logic                    r_pending;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [3:0]              r_digit;
  logic                    r_frame;
  logic                    r_ack;

  logic                    w_tick;
  logic [IDXW-1:0]         w_next_idx;
  logic                    w_wrap;
  logic                    w_apply;
  logic [4*NUM_DIGITS-1:0] w_apply_data;
  logic [4*NUM_DIGITS-1:0] w_frame_data;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_an;
  logic                    w_blank;
  logic                    w_dark;

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          w_blink_sel;
`endif

  assign w_tick = (r_div == DW'(REFRESH_DIV - 1));

  always_comb begin
    w_next_idx = '0;
    if (r_state == ST_SCAN && r_idx != IDXW'(NUM_DIGITS - 1))
      w_next_idx = r_idx + 1'b1;
    w_wrap       = (w_next_idx == '0);
    // The slot that opens a frame also commits the staged digits, so it must
    // already show them; a load in that same cycle bypasses staging.
    w_apply      = w_tick && w_wrap && (r_pending || load);
    w_apply_data = load ? digits_in : r_staging;
    w_frame_data = w_apply ? w_apply_data : r_shadow;
    w_nibble     = 4'hF;
    w_blank      = 1'b0;
    w_an         = '1;
`ifdef SEG_SCAN_BLINK_EN
    w_blink_sel  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_next_idx == IDXW'(i)) begin
        w_nibble = w_frame_data[4*i +: 4];
        w_blank  = blank_mask[i];
        w_an[i]  = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        w_blink_sel = blink_mask[i];
`endif
      end
    end
`ifdef SEG_SCAN_BLINK_EN
    w_dark = w_blank | (r_phase & w_blink_sel);
`else
    w_dark = w_blank;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_staging <= '0;
      r_pending <= 1'b0;
      r_an      <= '1;
      r_digit   <= 4'hF;
      r_frame   <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_frame <= 1'b0;
      r_ack   <= 1'b0;
      if (w_apply) begin
        r_shadow  <= w_apply_data;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end else if (load) begin
        r_staging <= digits_in;
        r_pending <= 1'b1;
      end
      if (w_tick) begin
        r_state <= ST_SCAN;
        r_idx   <= w_next_idx;
        r_frame <= w_wrap;
        r_an    <= w_dark ? '1 : w_an;
        r_digit <= w_dark ? 4'hF : w_nibble;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end
`endif

  assign an          = r_an;
  assign digit_out   = r_digit;
  assign frame_start = r_frame;
  assign load_ack    = r_ack;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios followed by random
// traffic, compared every cycle against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int RD = 4;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic        load_ack;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles since reset release plus abstract data regs.
  int          m_cyc;
  logic [15:0] m_shadow, m_staging;
  bit          m_pending;
  logic [3:0]  e_an, e_dig;
  bit          e_fs, e_ack;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .NUM_DIGITS(ND), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .load       (load),
    .blank_mask (blank_mask),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask (4'b0000),
`endif
    .load_ack   (load_ack),
    .digit_out  (digit_out),
    .an         (an),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_shadow = '0; m_staging = '0; m_pending = 0;
    e_an = 4'hF; e_dig = 4'hF; e_fs = 0; e_ack = 0;
  endtask

  // One clock of the model: a slot tick every RD cycles, slot k shows digit k mod ND.
  task automatic model_step();
    int k, idx;
    bit tick;
    tick = (m_cyc % RD) == RD - 1;
    k    = m_cyc / RD;
    idx  = k % ND;
    e_fs = 0; e_ack = 0;
    if (tick && idx == 0 && (m_pending || load)) begin
      m_shadow  = load ? digits_in : m_staging;
      m_pending = 0;
      e_ack     = 1;
    end else if (load) begin
      m_staging = digits_in;
      m_pending = 1;
    end
    if (tick) begin
      e_fs = (idx == 0);
      if (blank_mask[idx]) begin
        e_an = 4'hF; e_dig = 4'hF;
      end else begin
        e_an  = ~(4'b0001 << idx);
        e_dig = (m_shadow >> (4 * idx)) & 16'hF;
      end
    end
    m_cyc++;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".an"}, 32'(an), 32'(e_an));
    chk({tag, ".digit"}, 32'(digit_out), 32'(e_dig));
    chk({tag, ".fs"}, 32'(frame_start), 32'(e_fs));
    chk({tag, ".ack"}, 32'(load_ack), 32'(e_ack));
  endtask

  // Starts and ends at a falling edge.
  task automatic cyc(input string tag, input bit ld, input logic [15:0] d, input logic [3:0] bm);
    load = ld; digits_in = d; blank_mask = bm;
    @(posedge clk);
    model_step();
    #1 check_outputs(tag);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input string tag, input int n, input logic [3:0] bm);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 16'h0000, bm);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; load = 1'b0;
    model_reset();
    #1 check_outputs({tag, ".async"});
    @(negedge clk);
    check_outputs({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Load 1234 at cycle 1, first tick at cycle 3.
    cyc("t1c0", 1'b0, 16'h0000, 4'b0000);
    cyc("t1c1", 1'b1, 16'h1234, 4'b0000);
    cyc("t1c2", 1'b0, 16'h0000, 4'b0000);
    cyc("t1c3", 1'b0, 16'h0000, 4'b0000);
    chk("t1.first_an", 32'(an), 32'h0000000E);
    chk("t1.first_dig", 32'(digit_out), 32'h4);
    chk("t1.first_fs_ack", 32'({frame_start, load_ack}), 32'h3);

    // Scan digits 3,2,1 then wrap.
    idle("t2", 12, 4'b0000);
    chk("t2.slot3_an", 32'(an), 32'h7);
    chk("t2.slot3_dig", 32'(digit_out), 32'h1);
    idle("t2w", 4, 4'b0000);

    // Mid-frame load while idx=1.
    cyc("t3ld", 1'b1, 16'h5678, 4'b0000);
    idle("t3", 23, 4'b0000);

    // Two loads in one frame, last wins, single ack.
    cyc("t4a", 1'b1, 16'h1111, 4'b0000);
    idle("t4", 2, 4'b0000);
    cyc("t4b", 1'b1, 16'h2222, 4'b0000);
    idle("t4r", 20, 4'b0000);

    // Blank slot 2.
    idle("t5", 16, 4'b0100);

    // Reset mid-frame with a load pending; no ack and zero shadow afterwards.
    cyc("t6ld", 1'b1, 16'h9ABC, 4'b0000);
    idle("t6", 2, 4'b0000);
    do_reset("rst6");
    idle("t6post", 20, 4'b0000);

    // Non-BCD nibbles pass through.
    cyc("nbcd", 1'b1, 16'hFEDA, 4'b0000);
    idle("nbcd", 20, 4'b0000);

    // Random traffic, with a load on the apply tick occasionally.
    for (int i = 0; i < 400; i++) begin
      bit          ld;
      logic [15:0] d;
      logic [3:0]  bm;
      ld = ($urandom_range(0, 5) == 0);
      d  = 16'($urandom);
      bm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cyc("rnd", ld, d, bm);
      if (i == 200) begin
        do_reset("rstr");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
